// File: rtl/alu_pkg.sv
// Shared types and tables for the shared-ALU request controller.
// Optional round-robin arbitration is enabled with ALU_SHARE_RR_EN.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_SHIFT = 3'd3,
    OP_OR    = 3'd4,
    OP_NOT   = 3'd5,
    OP_XOR   = 3'd6,
    OP_NAND  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } share_state_t;

  localparam int LAT_W = 2;

  // Bit n set means opcode n produces a meaningful carry/borrow.
  localparam logic [7:0] ALU_CARRY_MASK = 8'b0000_0011;

  // The shifter registers its result, so SHIFT needs one extra EXEC cycle.
  function automatic logic [LAT_W-1:0] ALU_OP_LAT(input alu_op_t op);
    return (op == OP_SHIFT) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/alu_share_arb.sv
// Two-way request arbiter producing a one-hot grant.
// ALU_SHARE_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module alu_share_arb (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef ALU_SHARE_RR_EN
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = 2'b00;
    if (req_valid[0]) begin
      grant = 2'b01;
    end else if (req_valid[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: arbitrate, latch operands, wait the
// op latency, capture the result and hand it back. Macro: ALU_SHARE_RR_EN.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [2:0]      req0_op,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic            req0_shift,
  input  logic [2:0]      req1_op,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic            req1_shift,
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_cout,
  output logic [2:0]      alu_sel,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic            alu_shift,
  input  logic [W-1:0]    alu_o,
  input  logic            alu_cout,
  output logic            busy
);

  share_state_t     state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             shift_q, shift_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic [W-1:0]     data_q, data_d;
  logic             cout_q, cout_d;

  logic [1:0] grant;
  logic       last_grant;
  logic       accept;
  logic       rsp_hs;

  alu_share_arb u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // grant is already qualified by req_valid, so any grant in IDLE is a handshake.
  assign accept = (state_q == ST_IDLE) && (grant != 2'b00);
  assign rsp_hs = (state_q == ST_RESP) && rsp_ready[owner_q];

`ifdef ALU_SHARE_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)            state_d = ST_EXEC;
      ST_EXEC: if (cnt_q == 2'd1)     state_d = ST_RESP;
      ST_RESP: if (rsp_hs)            state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != ST_IDLE);
    if ((state_q == ST_IDLE) && !rst) begin
      req_ready = grant;
    end
    if (state_q == ST_RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    data_d  = data_q;
    cout_d  = cout_q;
    if (accept) begin
      op_d    = alu_op_t'(grant[1] ? req1_op : req0_op);
      a_d     = grant[1] ? req1_a : req0_a;
      b_d     = grant[1] ? req1_b : req0_b;
      shift_d = grant[1] ? req1_shift : req0_shift;
      cnt_d   = ALU_OP_LAT(op_d);
      owner_d = grant[1];
    end else if (state_q == ST_EXEC) begin
      cnt_d = cnt_q - 2'd1;
      if (cnt_q == 2'd1) begin
        data_d = alu_o;
        cout_d = alu_cout & ALU_CARRY_MASK[op_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      shift_q <= 1'b0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      data_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      cout_q  <= cout_d;
    end
  end

  assign alu_sel   = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_shift = shift_q;
  assign rsp_data  = data_q;
  assign rsp_cout  = cout_q;

endmodule
